// File: rtl/sram_pkg.sv
// Shared types and constants for the pipeline data-memory SRAM controller.
package sram_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } sram_state_t;

  localparam int unsigned SRAM_ADDR_W    = 18;
  localparam int unsigned SRAM_DATA_W    = 16;
  localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter; last flags the final cycle of an ACCESS_CYCLES-long phase.
module sram_wait_counter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic last
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 4'd1;
    end
  end

  assign last = (count == 4'(ACCESS_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit pipeline load/store into two 16-bit SRAM accesses,
// holding ready low until the pair completes.
module sram_controller
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = SRAM_BASE_ADDR,
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            wr_data,
  output logic [31:0]            rd_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [SRAM_DATA_W-1:0] sram_dq_o,
  input  logic [SRAM_DATA_W-1:0] sram_dq_i,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  sram_state_t state, state_next;
  logic        last;
  logic        clear;
  logic        count_en;
  logic [31:0] offset;
  logic [16:0] word;
  logic        unused_offset_bits;

  // Byte offset into the SRAM window; only 17 word-index bits reach the device.
  assign offset             = address - BASE_ADDR;
  assign word               = offset[18:2];
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

  sram_wait_counter #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_wait (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .en   (count_en),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (wr_en) begin
          state_next = WR_LO;
        end else if (rd_en) begin
          state_next = RD_LO;
        end
      end
      RD_LO:   if (last) state_next = RD_HI;
      RD_HI:   if (last) state_next = DONE;
      WR_LO:   if (last) state_next = WR_HI;
      WR_HI:   if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign clear    = (state_next != state);
  assign count_en = (state == RD_LO) || (state == RD_HI) ||
                    (state == WR_LO) || (state == WR_HI);
  assign ready    = ((state == IDLE) && !rd_en && !wr_en) || (state == DONE);

  // SRAM pins are loaded only when the FSM changes state, so they stay glitch-free per phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
      rd_data    <= '0;
    end else begin
      if (state_next != state) begin
        sram_addr  <= '0;
        sram_dq_o  <= '0;
        sram_dq_oe <= 1'b0;
        sram_we_n  <= 1'b1;
        unique case (state_next)
          RD_LO: sram_addr <= {word, 1'b0};
          RD_HI: sram_addr <= {word, 1'b1};
          WR_LO: begin
            sram_addr  <= {word, 1'b0};
            sram_dq_o  <= wr_data[15:0];
            sram_dq_oe <= 1'b1;
            sram_we_n  <= 1'b0;
          end
          WR_HI: begin
            sram_addr  <= {word, 1'b1};
            sram_dq_o  <= wr_data[31:16];
            sram_dq_oe <= 1'b1;
            sram_we_n  <= 1'b0;
          end
          default: ;
        endcase
      end
      if ((state == RD_LO) && last) begin
        rd_data[15:0] <= sram_dq_i;
      end
      if ((state == RD_HI) && last) begin
        rd_data[31:16] <= sram_dq_i;
      end
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: SRAM model with a minimum write-pulse rule,
// scoreboard queues of expected halfword writes and load results.
module tb_sram_controller;
  import sram_pkg::*;

  localparam int MODEL_ACC = 2;

  logic        clk;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, wr_data, rd_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_we_n;

  logic        rd_en_b, wr_en_b;
  logic [31:0] address_b, wr_data_b, rd_data_b;
  logic        ready_b;
  logic [17:0] sram_addr_b;
  logic [15:0] sram_dq_o_b, sram_dq_i_b;
  logic        sram_dq_oe_b, sram_we_n_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [256];
  logic        bd_en = 1'b0;
  logic [7:0]  bd_addr = '0;
  logic [15:0] bd_data = '0;
  logic [17:0] prev_addr = '0;
  logic        prev_we_n = 1'b1;
  int          hold = 0;
  int          hold_next;

  logic [33:0] exp_wr[$];
  logic [33:0] obs_wr[$];
  logic [31:0] exp_rd[$];
  int          obs_low, obs_we_low;
  bit          obs_done;
  logic [31:0] obs_rd;

  sram_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
    .sram_we_n(sram_we_n)
  );

  sram_controller #(.BASE_ADDR(32'd1024), .ACCESS_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .rd_en(rd_en_b), .wr_en(wr_en_b), .address(address_b),
    .wr_data(wr_data_b), .rd_data(rd_data_b), .ready(ready_b), .sram_addr(sram_addr_b),
    .sram_dq_o(sram_dq_o_b), .sram_dq_i(sram_dq_i_b), .sram_dq_oe(sram_dq_oe_b),
    .sram_we_n(sram_we_n_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // A halfword commits only after we_n has been held at one address for MODEL_ACC edges.
  assign sram_dq_i   = mem[sram_addr[7:0]];
  assign sram_dq_i_b = mem[sram_addr_b[7:0]];
  assign hold_next   = (!sram_we_n && !prev_we_n && sram_addr == prev_addr) ? hold + 1 : 1;

  always @(posedge clk) begin
    if (!sram_we_n && hold_next == MODEL_ACC) mem[sram_addr[7:0]] <= sram_dq_o;
    if (bd_en) mem[bd_addr] <= bd_data;
    hold      <= sram_we_n ? 0 : hold_next;
    prev_we_n <= sram_we_n;
    prev_addr <= sram_addr;
  end

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    bd_en = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_en = 1'b0;
  endtask

  task automatic run_access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    logic [33:0] last_rec;
    bit          have;
    have = 0; last_rec = '0;
    obs_low = 0; obs_we_low = 0; obs_done = 0; obs_rd = '0;
    obs_wr.delete();
    rd_en = r; wr_en = w; address = a; wr_data = d;
    for (int c = 0; c < 40 && !obs_done; c++) begin
      @(negedge clk);
      if (!sram_we_n) begin
        obs_we_low++;
        if (!have || last_rec != {sram_addr, sram_dq_o}) begin
          last_rec = {sram_addr, sram_dq_o};
          obs_wr.push_back(last_rec);
          have = 1;
        end
      end
      if (ready) begin
        obs_done = 1; obs_rd = rd_data;
        rd_en = 1'b0; wr_en = 1'b0;
      end else begin
        obs_low++;
      end
    end
    rd_en = 1'b0; wr_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; rd_en = 1'b1; wr_en = 1'b0; address = 32'd1024; wr_data = '0;
    rd_en_b = 1'b0; wr_en_b = 1'b0; address_b = 32'd1024; wr_data_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_req: got %b expected 0", ready); end
    n_checks++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n: got %b expected 1", sram_we_n); end
    n_checks++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", sram_dq_oe); end
    n_checks++; if (sram_addr !== 18'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", sram_addr); end
    n_checks++; if (sram_dq_o !== 16'd0) begin n_fail++; $display("FAIL reset_dq_o: got %h expected 0", sram_dq_o); end
    n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
    n_checks++; if (rd_data_b !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data_b: got %h expected 0", rd_data_b); end
    rd_en = 1'b0; #1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_idle: got %b expected 1", ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read;
    logic [33:0] e, o;
    exp_wr.push_back({18'd0, 16'hBEEF});
    exp_wr.push_back({18'd1, 16'hDEAD});
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    n_checks++; if (!obs_done) begin n_fail++; $display("FAIL wr_timeout: ready never rose"); end
    n_checks++; if (obs_low != 5) begin n_fail++; $display("FAIL wr_stall: got %0d low cycles expected 5", obs_low); end
    n_checks++; if (obs_we_low != 4) begin n_fail++; $display("FAIL wr_we_n_low: got %0d cycles expected 4", obs_we_low); end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      n_checks++;
      if (obs_wr.size() == 0) begin n_fail++; $display("FAIL wr_phase: got none expected %h", e); end
      else begin o = obs_wr.pop_front(); if (o !== e) begin n_fail++; $display("FAIL wr_phase: got %h expected %h", o, e); end end
    end
    n_checks++; if (obs_wr.size() != 0) begin n_fail++; $display("FAIL wr_extra: got %0d extra phases expected 0", obs_wr.size()); end
    exp_rd.push_back(32'hDEADBEEF);
    run_access(1'b1, 1'b0, 32'd1024, 32'h0);
    n_checks++; if (obs_low != 5) begin n_fail++; $display("FAIL rd_stall: got %0d low cycles expected 5", obs_low); end
    n_checks++; if (obs_we_low != 0) begin n_fail++; $display("FAIL rd_we_n: got %0d write cycles expected 0", obs_we_low); end
    n_checks++; if (obs_rd !== exp_rd.pop_front()) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", obs_rd); end
  endtask

  task automatic test_address_map;
    logic [33:0] e, o;
    exp_wr.push_back({18'd10, 16'h5678});
    exp_wr.push_back({18'd11, 16'h1234});
    run_access(1'b0, 1'b1, 32'd1024 + 32'd23, 32'h12345678);
    n_checks++; if (obs_low != 5) begin n_fail++; $display("FAIL map_stall: got %0d expected 5", obs_low); end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      n_checks++;
      if (obs_wr.size() == 0) begin n_fail++; $display("FAIL map_phase: got none expected %h", e); end
      else begin o = obs_wr.pop_front(); if (o !== e) begin n_fail++; $display("FAIL map_phase: got %h expected %h", o, e); end end
    end
    n_checks++; if (mem[10] !== 16'h5678) begin n_fail++; $display("FAIL map_mem10: got %h expected 5678", mem[10]); end
    n_checks++; if (mem[11] !== 16'h1234) begin n_fail++; $display("FAIL map_mem11: got %h expected 1234", mem[11]); end
  endtask

  task automatic test_simultaneous;
    logic [33:0] e, o;
    exp_wr.push_back({18'd4, 16'hF00D});
    exp_wr.push_back({18'd5, 16'hCAFE});
    run_access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D);
    n_checks++; if (obs_we_low != 4) begin n_fail++; $display("FAIL both_we_n: got %0d expected 4", obs_we_low); end
    n_checks++; if (obs_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL both_rd_data: got %h expected deadbeef", obs_rd); end
    while (exp_wr.size() > 0) begin
      e = exp_wr.pop_front();
      n_checks++;
      if (obs_wr.size() == 0) begin n_fail++; $display("FAIL both_phase: got none expected %h", e); end
      else begin o = obs_wr.pop_front(); if (o !== e) begin n_fail++; $display("FAIL both_phase: got %h expected %h", o, e); end end
    end
  endtask

  task automatic test_back_to_back;
    preload(8'd2, 16'h1111); preload(8'd3, 16'h2222);
    preload(8'd6, 16'h3333); preload(8'd7, 16'h4444);
    exp_rd.push_back(32'h22221111);
    exp_rd.push_back(32'h44443333);
    run_access(1'b1, 1'b0, 32'd1028, 32'h0);
    n_checks++; if (obs_low != 5) begin n_fail++; $display("FAIL b2b_stall0: got %0d expected 5", obs_low); end
    n_checks++; if (obs_rd !== exp_rd.pop_front()) begin n_fail++; $display("FAIL b2b_rd0: got %h expected 22221111", obs_rd); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_gap: got ready %b expected 1", ready); end
    run_access(1'b1, 1'b0, 32'd1036, 32'h0);
    n_checks++; if (obs_low != 5) begin n_fail++; $display("FAIL b2b_stall1: got %0d expected 5", obs_low); end
    n_checks++; if (obs_rd !== exp_rd.pop_front()) begin n_fail++; $display("FAIL b2b_rd1: got %h expected 44443333", obs_rd); end
  endtask

  task automatic test_reset_mid_access;
    preload(8'd8, 16'h0000); preload(8'd9, 16'h0000);
    wr_en = 1'b1; address = 32'd1040; wr_data = 32'hAAAA5555;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (sram_addr !== 18'd9 || sram_we_n !== 1'b0) begin
      n_fail++; $display("FAIL mid_in_wr_hi: got addr %h we_n %b expected 9 0", sram_addr, sram_we_n); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL mid_we_n: got %b expected 1", sram_we_n); end
    n_checks++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL mid_oe: got %b expected 0", sram_dq_oe); end
    n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL mid_rd_data: got %h expected 0", rd_data); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mid_idle_req: got ready %b expected 0", ready); end
    wr_en = 1'b0; #1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mid_idle: got ready %b expected 1", ready); end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (mem[8] !== 16'h5555) begin n_fail++; $display("FAIL mid_mem_lo: got %h expected 5555", mem[8]); end
    n_checks++; if (mem[9] !== 16'h0000) begin n_fail++; $display("FAIL mid_mem_hi: got %h expected 0000", mem[9]); end
  endtask

  task automatic test_access1;
    int  low;
    bit  done;
    logic [31:0] snap;
    low = 0; done = 0; snap = '0;
    preload(8'd20, 16'h5A5A); preload(8'd21, 16'hA5A5);
    exp_rd.push_back(32'hA5A55A5A);
    rd_en_b = 1'b1; address_b = 32'd1064;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      n_checks++; if (sram_we_n_b !== 1'b1) begin n_fail++; $display("FAIL acc1_we_n: got %b expected 1", sram_we_n_b); end
      if (ready_b) begin done = 1; snap = rd_data_b; rd_en_b = 1'b0; end
      else low++;
    end
    rd_en_b = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (!done) begin n_fail++; $display("FAIL acc1_timeout: ready never rose"); end
    n_checks++; if (low != 3) begin n_fail++; $display("FAIL acc1_stall: got %0d expected 3", low); end
    n_checks++; if (snap !== exp_rd.pop_front()) begin n_fail++; $display("FAIL acc1_rd_data: got %h expected a5a55a5a", snap); end
    n_checks++; if (sram_addr_b !== 18'd0 || sram_dq_o_b !== 16'd0 || sram_dq_oe_b !== 1'b0) begin
      n_fail++; $display("FAIL acc1_idle_pins: got addr %h dq %h oe %b expected 0 0 0", sram_addr_b, sram_dq_o_b, sram_dq_oe_b); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_address_map();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_access();
    test_access1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-side responder for the pipeline's data-memory requests. The MEM stage drives the execute stage's `mem_read`/`mem_write` request, using `alu_result` as the address and `val_Rm` as store data. This block services each 32-bit request as two 16-bit accesses to an external SRAM and holds `ready` low to freeze the pipeline until the access completes.

## Interface
Parameters:
- `BASE_ADDR`, default 1024. Byte address that maps to SRAM word 0.
- `ACCESS_CYCLES`, default 2. Cycles each 16-bit SRAM access is held. Legal range 1–15.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `rd_en`  in  1  read request (MEM-stage `mem_read`).
- `wr_en`  in  1  write request (MEM-stage `mem_write`).
- `address`  in  32  byte address (ALU result).
- `wr_data`  in  32  store data (`val_Rm`).
- `rd_data`  out  32  load result.
- `ready`  out  1  high when no access is pending. Low means freeze the pipeline.
- `sram_addr`  out  18  halfword address to SRAM.
- `sram_dq_o`  out  16  write data to SRAM.
- `sram_dq_i`  in  16  read data from SRAM.
- `sram_dq_oe`  out  1  drive enable for `sram_dq_o`.
- `sram_we_n`  out  1  SRAM write enable, active-low.

## Operation
- Word index: `word = (address - BASE_ADDR) >> 2`, computed mod 2^32.
  - Bits [1:0] of `address` are ignored.
  - Only `word[16:0]` is used.
- Halfword addresses: low half at `{word[16:0],1'b0}`, high half at `{word[16:0],1'b1}`.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
  - IDLE → WR_LO if `wr_en`. Write wins if `rd_en` and `wr_en` are both high.
  - IDLE → RD_LO if only `rd_en`.
  - RD_LO → RD_HI and WR_LO → WR_HI after `ACCESS_CYCLES` cycles in the state.
  - RD_HI/WR_HI → DONE after `ACCESS_CYCLES` cycles.
  - DONE → IDLE unconditionally.
- Wait counter: cleared on every state entry; the phase ends when counter == `ACCESS_CYCLES-1`.
- Read:
  - Sample `sram_dq_i` into `rd_data[15:0]` on the last cycle of RD_LO.
  - Sample `sram_dq_i` into `rd_data[31:16]` on the last cycle of RD_HI.
  - `rd_data` is held until the next read overwrites it. Writes never change it.
- Write:
  - WR_LO drives `wr_data[15:0]`; WR_HI drives `wr_data[31:16]`.
  - `sram_we_n=0` and `sram_dq_oe=1` throughout WR_LO/WR_HI only.
  - `wr_data` and `address` are sampled live. The pipeline holds them stable while `ready=0`.
- `ready` is combinational: `(IDLE && !rd_en && !wr_en) || DONE`.
- DONE always returns to IDLE. A request present in IDLE on the cycle after DONE is treated as a new access.

## Timing
- Reset values: state IDLE, counter 0, `rd_data=0`, `sram_addr=0`, `sram_dq_o=0`, `sram_dq_oe=0`, `sram_we_n=1`.
- `ready` after reset follows the request inputs.
- Latency with request asserted in IDLE at cycle 0:
  - `ready` is low for cycles 0 .. 2·`ACCESS_CYCLES`.
  - `ready` is high in cycle 2·`ACCESS_CYCLES`+1 (DONE).
  - With the default, that is cycles 0–4 low and cycle 5 high.
- `rd_data` is valid from DONE onward, registered with no combinational path from `sram_dq_i`.
- `sram_addr`, `sram_we_n`, `sram_dq_o` and `sram_dq_oe` are registered: they change only at state transitions.
- In IDLE, outputs are driven to their reset values.
- Reset mid-access: the next edge forces all reset values.
  - A partial write is abandoned; only the low half may have been written.
  - The pipeline re-executes after reset.
- A request dropped mid-access does not abort it; the FSM completes to DONE.

## Structure
- Shared package `sram_pkg` holds:
  - state enum `sram_state_t`;
  - `SRAM_ADDR_W=18` and `SRAM_DATA_W=16`;
  - default `BASE_ADDR`.
- One sub-module, `sram_wait_counter`, a 4-bit counter with:
  - inputs `clear` and `en`;
  - output `last`, asserted when count == `ACCESS_CYCLES-1`.
- FSM, address calculation and the `rd_data` register stay in `sram_controller`.

## Test plan
- Write then read, `ACCESS_CYCLES=2`:
  - Write `address=1024`, `wr_data=0xDEADBEEF` → `sram_addr` 0 then 1, with `sram_dq_o` 0xBEEF then 0xDEAD.
  - `sram_we_n` is low for 4 cycles; `ready` is low for cycles 0–4 and high in cycle 5.
  - Read of the same address with the SRAM model → `rd_data=0xDEADBEEF` in DONE.
- Address map: write to `address=1024+4*5+3` → `sram_addr` 10 and 11, since the low bits are ignored.
- Simultaneous `rd_en=1` and `wr_en=1` at `address=1032` → write path taken (`sram_we_n=0`) and `rd_data` unchanged.
- Back-to-back reads at 1028 then 1036 → two separate 5-cycle stalls, with DONE→IDLE between them and `rd_data` updated in each DONE.
- Reset mid-access: `rst=0` during WR_HI → next cycle `sram_we_n=1`, `sram_dq_oe=0`, `rd_data=0`, state IDLE; only SRAM halfword 2k holds new data.
- `ACCESS_CYCLES=1`: read → `ready` low for 3 cycles and high in the 4th.
